mesh_term_port: RTL and testbench

- Terminal-side endpoint attached to one of the 2*ROWS+2*COLUMS edge ports of the mesh emulator.
- It sits upstream of the mesh on transmit: it assembles packets, buffers them, and presents them via pndng/data with pop-by-mesh (popin) handshake.
- It sits downstream of the mesh on receive: it pops delivered packets, checks destination, and hands them to the test environment.
- It keeps saturating traffic/error counters used by the scoreboard.

---
 rtl/mesh_term_port.sv | 168 ++++++++++++++++
 tb/tb_mesh_term_port.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_term_port.sv
// Terminal endpoint for one mesh edge port: TX packet assembly into a FWFT FIFO,
// paced RX pop with destination check, and saturating traffic/error statistics.
module mesh_term_port #(
  parameter int unsigned pckg_sz    = 40,
  parameter int unsigned fifo_depth = 4,
  parameter int unsigned id_r       = 0,
  parameter int unsigned id_c       = 0,
  parameter int unsigned cnt_w      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tx_push,
  input  logic [3:0]         tx_row,
  input  logic [3:0]         tx_col,
  input  logic               tx_mode,
  input  logic [pckg_sz-18:0] tx_payload,
  output logic               tx_full,
  output logic               pndng_o,
  output logic [pckg_sz-1:0] data_o,
  input  logic               popin,
  input  logic               pndng_i,
  input  logic [pckg_sz-1:0] data_i,
  output logic               pop_o,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  input  logic               rx_ready,
  output logic [cnt_w-1:0]   tx_cnt,
  output logic [cnt_w-1:0]   rx_cnt,
  output logic [cnt_w-1:0]   err_cnt,
  output logic               tx_overflow,
  output logic               proto_err
);

  localparam int unsigned PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int unsigned CW = $clog2(fifo_depth + 1);

  typedef enum logic [1:0] {
    IDLE,
    POP,
    GAP0,
    GAP1
  } rx_state_e;

  function automatic logic [cnt_w-1:0] sat_inc(input logic [cnt_w-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(fifo_depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------- TX FIFO ----------------
  logic [pckg_sz-1:0] mem_q [fifo_depth];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [cnt_w-1:0]   tx_cnt_q, tx_cnt_d;
  logic               tx_ovf_q, tx_ovf_d;
  logic               proto_q, proto_d;
  logic               nonempty, full, pop_ok, push_ok;
  logic [pckg_sz-1:0] tx_word;

  assign tx_word  = {8'h00, tx_row, tx_col, tx_mode, tx_payload};
  assign nonempty = (count_q != '0);
  assign full     = (count_q == CW'(fifo_depth));

  always_comb begin
    pop_ok   = popin && nonempty;
    // A pop in the same edge frees the slot, so a push into a full FIFO is still taken.
    push_ok  = tx_push && (!full || pop_ok);
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
    tx_cnt_d = pop_ok ? sat_inc(tx_cnt_q) : tx_cnt_q;
    tx_ovf_d = tx_ovf_q | (tx_push & ~push_ok);
    proto_d  = proto_q | (popin & ~nonempty);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tx_cnt_q <= '0;
      tx_ovf_q <= 1'b0;
      proto_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tx_cnt_q <= tx_cnt_d;
      tx_ovf_q <= tx_ovf_d;
      proto_q  <= proto_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= tx_word;
    end
  end

  assign pndng_o     = nonempty;
  assign data_o      = nonempty ? mem_q[rd_ptr_q] : '0;
  assign tx_full     = full;
  assign tx_cnt      = tx_cnt_q;
  assign tx_overflow = tx_ovf_q;
  assign proto_err   = proto_q;

  // ---------------- RX path ----------------
  rx_state_e          state_q, state_d;
  logic               capture, misroute;
  logic               rx_valid_q, rx_valid_d;
  logic [pckg_sz-1:0] rx_data_q, rx_data_d;
  logic [cnt_w-1:0]   rx_cnt_q, rx_cnt_d;
  logic [cnt_w-1:0]   err_cnt_q, err_cnt_d;

  assign misroute = (data_i[pckg_sz-9 -: 4] != 4'(id_r)) ||
                    (data_i[pckg_sz-13 -: 4] != 4'(id_c));

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: if (pndng_i && !rx_valid_q) state_d = POP;
      POP: begin
        capture = 1'b1;
        state_d = GAP0;
      end
      // Two idle cycles let the mesh's registered pndng reflect the pop.
      GAP0:    state_d = GAP1;
      GAP1:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rx_valid_d = capture ? 1'b1 : (rx_ready ? 1'b0 : rx_valid_q);
    rx_data_d  = capture ? data_i : rx_data_q;
    rx_cnt_d   = capture ? sat_inc(rx_cnt_q) : rx_cnt_q;
    err_cnt_d  = (capture && misroute) ? sat_inc(err_cnt_q) : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_cnt_q   <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_cnt_q   <= rx_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign pop_o    = (state_q == POP);
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign rx_cnt   = rx_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_mesh_term_port.sv
// Directed bench for mesh_term_port: TX/RX scoreboards with a small mesh model.
module tb_mesh_term_port;
  localparam int unsigned PS  = 40;
  localparam int unsigned D   = 4;
  localparam int unsigned IDR = 1;
  localparam int unsigned IDC = 2;
  localparam int unsigned CW  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           tx_push, tx_mode, popin, rx_ready;
  logic [3:0]     tx_row, tx_col;
  logic [PS-18:0] tx_payload;
  logic           tx_full, pndng_o, pop_o, rx_valid, tx_overflow, proto_err;
  logic [PS-1:0]  data_o, rx_data;
  logic           pndng_i = 1'b0;
  logic [PS-1:0]  data_i = '0;
  logic [CW-1:0]  tx_cnt, rx_cnt, err_cnt;

  mesh_term_port #(
    .pckg_sz(PS), .fifo_depth(D), .id_r(IDR), .id_c(IDC), .cnt_w(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .tx_push(tx_push), .tx_row(tx_row), .tx_col(tx_col), .tx_mode(tx_mode),
    .tx_payload(tx_payload), .tx_full(tx_full),
    .pndng_o(pndng_o), .data_o(data_o), .popin(popin),
    .pndng_i(pndng_i), .data_i(data_i), .pop_o(pop_o),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .err_cnt(err_cnt),
    .tx_overflow(tx_overflow), .proto_err(proto_err)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  logic [PS-1:0] tx_exp[$];
  logic [PS-1:0] mesh_q[$];
  logic [PS-1:0] rx_exp[$];
  int pop_times[$];
  int  mcount = 0;
  int  m_txcnt = 0;
  bit  m_ovf = 0;
  bit  m_proto = 0;
  logic rxv_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Mesh model: registered pndng/data, one packet removed per pop_o cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && pop_o && mesh_q.size() > 0) void'(mesh_q.pop_front());
    pndng_i <= rst && (mesh_q.size() != 0);
    data_i  <= (mesh_q.size() != 0) ? mesh_q[0] : '0;
  end

  always @(negedge clk) begin
    if (pop_o) pop_times.push_back(cyc);
    if (rx_valid && !rxv_prev) begin
      if (rx_exp.size() == 0) chk("rx_spurious", rx_valid, 0);
      else chk("rx_data", rx_data, rx_exp.pop_front());
    end
    rxv_prev = rx_valid;
  end

  // One TX cycle, entered and left at a falling edge.
  task automatic txc(input bit push, input logic [3:0] r, input logic [3:0] c,
                     input bit m, input logic [22:0] pl, input bit pop);
    logic [PS-1:0] w;
    bit pop_ok, push_ok;
    w = {8'h00, r, c, m, pl};
    tx_push = push; tx_row = r; tx_col = c; tx_mode = m; tx_payload = pl; popin = pop;
    pop_ok  = pop && (mcount > 0);
    push_ok = push && ((mcount < D) || pop_ok);
    if (pop_ok) begin
      chk("tx_head", data_o, tx_exp.pop_front());
      m_txcnt++;
    end
    if (pop && mcount == 0) m_proto = 1;
    if (push && !push_ok) m_ovf = 1;
    if (push_ok) tx_exp.push_back(w);
    mcount = mcount + int'(push_ok) - int'(pop_ok);
    @(negedge clk);
    tx_push = 1'b0; popin = 1'b0;
    chk("pndng_o", pndng_o, mcount != 0);
    chk("tx_full", tx_full, mcount == D);
    chk("tx_cnt", tx_cnt, m_txcnt);
    chk("tx_overflow", tx_overflow, m_ovf);
    chk("proto_err", proto_err, m_proto);
    if (mcount == 0) chk("data_o_empty", data_o, 0);
  endtask

  task automatic wait_rx(input int n, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (rx_cnt == CW'(n)) break;
      @(negedge clk);
    end
    chk("rx_cnt_reached", rx_cnt, n);
  endtask

  function automatic logic [PS-1:0] rx_pkt(input logic [3:0] r, input logic [3:0] c,
                                           input logic [22:0] pl);
    return {8'h00, r, c, 1'b0, pl};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    rst = 1'b0; tx_push = 1'b0; tx_row = '0; tx_col = '0; tx_mode = 1'b0;
    tx_payload = '0; popin = 1'b0; rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_pndng_o", pndng_o, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_pop_o", pop_o, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_counters", {tx_cnt, rx_cnt, err_cnt}, 0);
    chk("rst_flags", {tx_overflow, proto_err}, 0);

    // TX ordering and packet format
    txc(1, 4'd2, 4'd3, 1, 23'h00ABCD, 0);
    txc(1, 4'd4, 4'd1, 0, 23'h000001, 0);
    chk("fmt_first", data_o, 40'h0023_80ABCD);
    txc(0, 0, 0, 0, 0, 1);
    chk("fmt_second", data_o, 40'h0041_000001);
    txc(0, 0, 0, 0, 0, 1);
    chk("tx_cnt_two", tx_cnt, 2);

    // Fill, overflow, push+pop while full, drain (pointers wrap)
    for (int i = 0; i < 5; i++) txc(1, 4'(i), 4'(i + 1), i[0], 23'h100 + 23'(i), 0);
    chk("ovf_sticky", tx_overflow, 1);
    txc(1, 4'd7, 4'd7, 1, 23'h1FF, 1);
    chk("full_after_swap", tx_full, 1);
    for (int i = 0; i < 4; i++) txc(0, 0, 0, 0, 0, 1);

    // Pop while empty, then push+pop on empty FIFO
    txc(0, 0, 0, 0, 0, 1);
    chk("proto_sticky", proto_err, 1);
    txc(1, 4'd5, 4'd6, 0, 23'h2AA, 1);
    chk("empty_swap_pndng", pndng_o, 1);
    txc(0, 0, 0, 0, 0, 1);

    // RX pacing and destination check
    rx_ready = 1'b1;
    mesh_q.push_back(rx_pkt(4'd1, 4'd2, 23'h11)); rx_exp.push_back(rx_pkt(4'd1, 4'd2, 23'h11));
    mesh_q.push_back(rx_pkt(4'd3, 4'd3, 23'h22)); rx_exp.push_back(rx_pkt(4'd3, 4'd3, 23'h22));
    mesh_q.push_back(rx_pkt(4'd1, 4'd2, 23'h33)); rx_exp.push_back(rx_pkt(4'd1, 4'd2, 23'h33));
    wait_rx(3, 60);
    repeat (4) @(negedge clk);
    chk("rx_pop_pulses", pop_times.size(), 3);
    if (pop_times.size() >= 3) begin
      chk("rx_spacing_1", pop_times[1] - pop_times[0], 4);
      chk("rx_spacing_2", pop_times[2] - pop_times[1], 4);
    end
    chk("err_cnt_one", err_cnt, 1);
    chk("rx_drained", rx_valid, 0);

    // RX backpressure
    pop_times.delete();
    rx_ready = 1'b0;
    mesh_q.push_back(rx_pkt(4'd1, 4'd2, 23'h44)); rx_exp.push_back(rx_pkt(4'd1, 4'd2, 23'h44));
    mesh_q.push_back(rx_pkt(4'd2, 4'd2, 23'h55)); rx_exp.push_back(rx_pkt(4'd2, 4'd2, 23'h55));
    repeat (20) @(negedge clk);
    chk("bp_one_pop", pop_times.size(), 1);
    chk("bp_valid_held", rx_valid, 1);
    chk("bp_rx_cnt", rx_cnt, 4);
    rx_ready = 1'b1;
    t0 = cyc;
    repeat (3) @(negedge clk);
    chk("bp_second_pop", pop_times.size(), 2);
    chk("bp_latency_le2", (pop_times.size() > 1) && (pop_times[1] - t0 <= 2), 1);
    wait_rx(5, 40);
    repeat (4) @(negedge clk);
    chk("bp_err_cnt", err_cnt, 2);

    // Asynchronous reset mid-activity
    txc(1, 4'd1, 4'd1, 0, 23'h7, 0);
    txc(1, 4'd1, 4'd2, 0, 23'h8, 0);
    mesh_q.push_back(rx_pkt(4'd1, 4'd2, 23'h66));
    for (int i = 0; i < 20; i++) begin
      if (pop_o) break;
      @(negedge clk);
    end
    chk("pre_rst_pop_o", pop_o, 1);
    chk("pre_rst_pndng_o", pndng_o, 1);
    #2 rst = 1'b0;
    mesh_q.delete(); tx_exp.delete(); rx_exp.delete();
    mcount = 0; m_txcnt = 0; m_ovf = 0; m_proto = 0;
    #1;
    chk("arst_pndng_o", pndng_o, 0);
    chk("arst_pop_o", pop_o, 0);
    chk("arst_data_o", data_o, 0);
    chk("arst_counters", {tx_cnt, rx_cnt, err_cnt}, 0);
    chk("arst_flags", {tx_overflow, proto_err}, 0);
    chk("arst_rx", {rx_valid, rx_data}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pop_times.delete();
    repeat (8) @(negedge clk);
    chk("post_rst_no_pop", pop_times.size(), 0);
    chk("post_rst_pndng_o", pndng_o, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
